// File: rtl/prf_freelist_pkg.sv
// Shared sizing and types for the physical register free list, rename table, RRAT and ROB.
package prf_freelist_pkg;

  localparam int PRF_SIZE = 64;
  localparam int ARF_SIZE = 32;
  localparam int PRF_IDX  = $clog2(PRF_SIZE);

  typedef logic [PRF_IDX-1:0] prf_tag_t;
  typedef logic [PRF_IDX:0]   fl_ptr_t;

  // Tags above the architectural range start out free; the rest of the ring is don't-care.
  function automatic prf_tag_t fl_reset_tag(int unsigned idx);
    return (idx < PRF_SIZE - ARF_SIZE) ? prf_tag_t'(ARF_SIZE + idx) : '0;
  endfunction

endpackage

// File: rtl/prf_freelist.sv
// Circular free list of PRF tags: two allocations from the head, two retirements into the tail,
// and single-cycle rewind of the head to the retired point on flush.
module prf_freelist
  import prf_freelist_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               used_1,
  input  logic               used_2,
  input  logic               retire_valid_1,
  input  logic [PRF_IDX-1:0] retire_old_1,
  input  logic               retire_valid_2,
  input  logic [PRF_IDX-1:0] retire_old_2,
  input  logic               flush,
  output logic [PRF_IDX-1:0] free_reg_1,
  output logic [PRF_IDX-1:0] free_reg_2,
  output logic               free_valid_1,
  output logic               free_valid_2,
  output logic [PRF_IDX:0]   free_count,
  output logic               err_underflow
);

  prf_tag_t fl_q [PRF_SIZE];

  fl_ptr_t  head_q, head_d;
  fl_ptr_t  tail_q, tail_d;
  fl_ptr_t  arch_q, arch_d;
  logic     err_q, err_d;

  fl_ptr_t  count;
  fl_ptr_t  count_d;
  fl_ptr_t  n_alloc;
  fl_ptr_t  n_ret;
  fl_ptr_t  grant;
  logic     over_req;
  prf_tag_t head_idx1;
  prf_tag_t slot2_idx;

  always_comb begin
    count     = tail_q - head_q;
    n_alloc   = fl_ptr_t'(used_1) + fl_ptr_t'(used_2);
    n_ret     = fl_ptr_t'(retire_valid_1) + fl_ptr_t'(retire_valid_2);
    // A flush cycle ignores allocation requests, so it can never underflow.
    over_req  = !flush && (n_alloc > count);
    grant     = flush ? '0 : (over_req ? count : n_alloc);
    tail_d    = tail_q + n_ret;
    arch_d    = arch_q + n_ret;
    head_d    = flush ? arch_d : (head_q + grant);
    err_d     = err_q | over_req;
    count_d   = tail_d - head_d;
    head_idx1 = head_q[PRF_IDX-1:0] + prf_tag_t'(1);
    slot2_idx = tail_q[PRF_IDX-1:0] + prf_tag_t'(retire_valid_1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(PRF_SIZE - ARF_SIZE);
      arch_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      arch_q <= arch_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PRF_SIZE; i++) begin
        fl_q[i] <= fl_reset_tag(i);
      end
    end else begin
      if (retire_valid_1) begin
        fl_q[tail_q[PRF_IDX-1:0]] <= retire_old_1;
      end
      if (retire_valid_2) begin
        fl_q[slot2_idx] <= retire_old_2;
      end
    end
  end

  assign free_reg_1    = fl_q[head_q[PRF_IDX-1:0]];
  assign free_reg_2    = fl_q[head_idx1];
  assign free_valid_1  = (count != '0);
  assign free_valid_2  = (count > fl_ptr_t'(1));
  assign free_count    = count;
  assign err_underflow = err_q;

  // Legal traffic never returns more tags than the ring can hold.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    count_d <= fl_ptr_t'(PRF_SIZE))
    else $error("prf_freelist: free count would exceed PRF_SIZE");

endmodule

// File: tb/tb_prf_freelist.sv
// Randomised and directed bench for prf_freelist against a queue-based model of free, in-flight and committed tags.
`timescale 1ns/1ps
module tb_prf_freelist;
  import prf_freelist_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               used_1 = 1'b0;
  logic               used_2 = 1'b0;
  logic               retire_valid_1 = 1'b0;
  logic [PRF_IDX-1:0] retire_old_1 = '0;
  logic               retire_valid_2 = 1'b0;
  logic [PRF_IDX-1:0] retire_old_2 = '0;
  logic               flush = 1'b0;
  logic [PRF_IDX-1:0] free_reg_1;
  logic [PRF_IDX-1:0] free_reg_2;
  logic               free_valid_1;
  logic               free_valid_2;
  logic [PRF_IDX:0]   free_count;
  logic               err_underflow;

  always #5 clock = ~clock;

  prf_freelist dut (
    .clock          (clock),
    .reset          (reset),
    .used_1         (used_1),
    .used_2         (used_2),
    .retire_valid_1 (retire_valid_1),
    .retire_old_1   (retire_old_1),
    .retire_valid_2 (retire_valid_2),
    .retire_old_2   (retire_old_2),
    .flush          (flush),
    .free_reg_1     (free_reg_1),
    .free_reg_2     (free_reg_2),
    .free_valid_1   (free_valid_1),
    .free_valid_2   (free_valid_2),
    .free_count     (free_count),
    .err_underflow  (err_underflow)
  );

  // Model: free tags in hand-out order, allocated-but-unretired tags in program order,
  // and tags currently holding committed architectural state.
  prf_tag_t m_free[$];
  prf_tag_t m_spec[$];
  prf_tag_t m_arch[$];
  bit       m_err;
  bit       chk_en = 1'b0;
  int       n_cmp  = 0;
  int       n_bad  = 0;
  int       n_txn  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_spec.delete();
    m_arch.delete();
    m_err = 1'b0;
    for (int i = 0; i < PRF_SIZE - ARF_SIZE; i++) m_free.push_back(prf_tag_t'(ARF_SIZE + i));
    for (int i = 0; i < ARF_SIZE; i++) m_arch.push_back(prf_tag_t'(i));
  endtask

  task automatic model_step(input bit u1, input bit u2, input bit rv1, input prf_tag_t o1,
                            input bit rv2, input prf_tag_t o2, input bit f);
    prf_tag_t got[$];
    int na;
    na = int'(u1) + int'(u2);
    if (!f) begin
      if (na > m_free.size()) begin
        m_err = 1'b1;
        na = m_free.size();
      end
      repeat (na) got.push_back(m_free.pop_front());
    end
    if (rv1) begin
      m_arch.push_back(m_spec.pop_front());
      m_free.push_back(o1);
    end
    if (rv2) begin
      m_arch.push_back(m_spec.pop_front());
      m_free.push_back(o2);
    end
    foreach (got[i]) m_spec.push_back(got[i]);
    if (f) begin
      m_free = {m_spec, m_free};
      m_spec.delete();
    end
  endtask

  task automatic take_arch(input prf_tag_t t);
    int idx;
    idx = -1;
    for (int i = 0; i < m_arch.size(); i++) if (idx < 0 && m_arch[i] == t) idx = i;
    if (idx >= 0) m_arch.delete(idx);
  endtask

  task automatic pick_arch(output prf_tag_t t);
    int idx;
    idx = $urandom_range(0, m_arch.size() - 1);
    t = m_arch[idx];
    m_arch.delete(idx);
  endtask

  // Called at negedge+1; returns at the following negedge+1 after the model has been compared.
  task automatic do_cycle(input bit u1, input bit u2, input bit rv1, input prf_tag_t o1,
                          input bit rv2, input prf_tag_t o2, input bit f);
    used_1 = u1;
    used_2 = u2;
    retire_valid_1 = rv1;
    retire_old_1 = o1;
    retire_valid_2 = rv2;
    retire_old_2 = o2;
    flush = f;
    model_step(u1, u2, rv1, o1, rv2, o2, f);
    n_txn++;
    $display("txn %0d: use=%b%b ret=%b%b flush=%b model_count=%0d", n_txn, u1, u2, rv1, rv2, f,
             m_free.size());
    @(negedge clock);
    #1;
  endtask

  task automatic alloc(input bit u1, input bit u2);
    do_cycle(u1, u2, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic retire_pair(input bit f);
    prf_tag_t a, b;
    pick_arch(a);
    pick_arch(b);
    do_cycle(1'b0, 1'b0, 1'b1, a, 1'b1, b, f);
  endtask

  task automatic rand_cycle(input bit allow_flush);
    bit u1, u2, rv1, rv2, f;
    prf_tag_t o1, o2;
    u1  = ($urandom_range(0, 3) != 0);
    u2  = ($urandom_range(0, 1) == 1);
    rv1 = (m_spec.size() >= 1) && ($urandom_range(0, 1) == 1);
    rv2 = (m_spec.size() >= (rv1 ? 2 : 1)) && ($urandom_range(0, 1) == 1);
    f   = allow_flush && ($urandom_range(0, 24) == 0);
    o1  = prf_tag_t'($urandom);
    o2  = prf_tag_t'($urandom);
    if (rv1) pick_arch(o1);
    if (rv2) pick_arch(o2);
    do_cycle(u1, u2, rv1, o1, rv2, o2, f);
  endtask

  task automatic check_reset_literals(input string tag);
    chk({tag, "_reg1"},  32'(free_reg_1), 32);
    chk({tag, "_reg2"},  32'(free_reg_2), 33);
    chk({tag, "_count"}, 32'(free_count), 32);
    chk({tag, "_v1"},    32'(free_valid_1), 1);
    chk({tag, "_v2"},    32'(free_valid_2), 1);
    chk({tag, "_err"},   32'(err_underflow), 0);
  endtask

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en && reset) begin
      chk("count", 32'(free_count), m_free.size());
      chk("valid1", 32'(free_valid_1), (m_free.size() >= 1) ? 1 : 0);
      chk("valid2", 32'(free_valid_2), (m_free.size() >= 2) ? 1 : 0);
      chk("err", 32'(err_underflow), 32'(m_err));
      if (m_free.size() >= 1) chk("reg1", 32'(free_reg_1), 32'(m_free[0]));
      if (m_free.size() >= 2) chk("reg2", 32'(free_reg_2), 32'(m_free[1]));
    end
  end

  initial begin
    prf_tag_t flush_tags[$];
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_literals("in_reset");
    #1 reset = 1'b1;
    chk_en = 1'b1;
    check_reset_literals("after_reset");

    for (int k = 0; k < 3; k++) begin
      alloc(1'b1, 1'b1);
      chk("pair_alloc_reg1", 32'(free_reg_1), 34 + 2 * k);
    end
    chk("pair_alloc_count", 32'(free_count), 26);

    alloc(1'b0, 1'b1);
    chk("used2_only_reg1", 32'(free_reg_1), 39);
    chk("used2_only_count", 32'(free_count), 25);

    repeat (12) alloc(1'b1, 1'b1);
    alloc(1'b1, 1'b0);
    chk("drained_count", 32'(free_count), 0);
    chk("drained_v1", 32'(free_valid_1), 0);

    take_arch(prf_tag_t'(5));
    take_arch(prf_tag_t'(7));
    do_cycle(1'b0, 1'b0, 1'b1, prf_tag_t'(5), 1'b1, prf_tag_t'(7), 1'b0);
    chk("retire_reg1", 32'(free_reg_1), 5);
    chk("retire_reg2", 32'(free_reg_2), 7);
    chk("retire_count", 32'(free_count), 2);

    // Retire the remaining 30 in-flight tags; the tail passes entry 63 on the way.
    repeat (15) retire_pair(1'b0);
    chk("wrap_count", 32'(free_count), 32);
    chk("wrap_head5", 32'(free_reg_1), 5);

    for (int k = 0; k < 10; k++) flush_tags.push_back(m_free[k]);
    repeat (5) alloc(1'b1, 1'b1);
    repeat (2) retire_pair(1'b0);
    begin
      prf_tag_t a;
      pick_arch(a);
      do_cycle(1'b1, 1'b1, 1'b1, a, 1'b0, '0, 1'b1);
    end
    chk("flush_count", 32'(free_count), 32);
    chk("flush_reg1", 32'(free_reg_1), 32'(flush_tags[5]));

    repeat (15) alloc(1'b1, 1'b1);
    alloc(1'b1, 1'b0);
    chk("pre_underflow_count", 32'(free_count), 1);
    alloc(1'b1, 1'b1);
    chk("underflow_count", 32'(free_count), 0);
    chk("underflow_err", 32'(err_underflow), 1);
    repeat (3) alloc(1'b0, 1'b0);
    chk("underflow_err_held", 32'(err_underflow), 1);

    repeat (800) rand_cycle(1'b1);

    @(posedge clock);
    #2 reset = 1'b0;
    used_1 = 1'b0;
    used_2 = 1'b0;
    retire_valid_1 = 1'b0;
    retire_valid_2 = 1'b0;
    flush = 1'b0;
    #1 check_reset_literals("mid_reset");
    model_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    check_reset_literals("after_mid_reset");

    repeat (800) rand_cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
